// File: rtl/input_conditioner.sv
// input_conditioner
//   Board-clock front end for the LED pattern FSM and its clock divider.
//   Every raw button and switch pin passes through a two-flop synchroniser
//   and a per-bit debounce counter. The accepted (stable) levels are
//   published directly. Button edges are turned into one-cycle press and
//   release pulses. The lowest-indexed pressed button is latched as the
//   divider speed selection.
//
// Ports
//   clk          board clock, all state updates on its rising edge
//   reset        synchronous, active-high reset
//   btn_raw      raw asynchronous push-button pins   [N_BTN]
//   sw_raw       raw asynchronous slide-switch pins  [N_SW]
//   btn_level    debounced button levels             [N_BTN]
//   btn_press    one-cycle pulse on debounced 0->1   [N_BTN]
//   btn_release  one-cycle pulse on debounced 1->0   [N_BTN]
//   sw_level     debounced switch levels             [N_SW]
//   speed_sel    index of the most recently pressed button
//   speed_valid  set once any press has been accepted since reset

module input_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned N_SW            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2500000,
    parameter int unsigned CNT_W           = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_level,
    output logic [1:0]       speed_sel,
    output logic             speed_valid
);

    // Buttons occupy the low bits and switches the high bits of one shared vector.
    localparam int unsigned N_IN = N_BTN + N_SW;
    // Count value at which a mismatching input has been stable long enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  raw_all;
    logic [N_IN-1:0]  sync1_q;
    logic [N_IN-1:0]  sync2_q;
    logic [N_IN-1:0]  stable_q;
    logic [N_IN-1:0]  stable_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];

    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_d;
    logic [1:0]       speed_sel_d;
    logic             speed_valid_d;

    assign raw_all = {sw_raw, btn_raw};

    // Two-flop synchroniser for every raw pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_all;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state. A mismatch must persist for DEBOUNCE_CYCLES consecutive
    // cycles. Any return to the stable value clears the run, so the counter
    // cannot exceed CNT_LAST and never wraps.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Edge pulses are computed from the stable level about to be loaded.
    // Each pulse then registers in the same cycle as the new level.
    always_comb begin
        press_d   = stable_d[N_BTN-1:0] & ~stable_q[N_BTN-1:0];
        release_d = ~stable_d[N_BTN-1:0] & stable_q[N_BTN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    // Speed latch next state. The scan runs from high to low index, so on
    // simultaneous presses the lowest set bit of the registered press vector wins.
    always_comb begin
        speed_sel_d   = speed_sel;
        speed_valid_d = speed_valid | (|btn_press);
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                speed_sel_d = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_sel   <= '0;
            speed_valid <= 1'b0;
        end else begin
            speed_sel   <= speed_sel_d;
            speed_valid <= speed_valid_d;
        end
    end

    assign btn_level = stable_q[N_BTN-1:0];
    assign sw_level  = stable_q[N_IN-1:N_BTN];

endmodule
